// File: rtl/multicycle_ctrl_if.sv
// Bus between the multicycle control FSM and its datapath / memory port.
// The master side (datapath) drives opcode, ALU flag and memory-ready; the
// slave side (controller) drives every control strobe and the debug state.
// Define MC_PERF_CNT_EN to add the 32-bit retired-instruction counter instRet.
interface multicycle_ctrl_if;
  logic [3:0]  OpCode;
  logic        zero;
  logic        memRdy;
  logic        irWrite;
  logic        pcWrite;
  logic        bra;
  logic        branch;
  logic        regWrite;
  logic        regDes;
  logic        aluSrc;
  logic        memR;
  logic        memW;
  logic        MemToReg;
  logic        notStri;
  logic        illegal;
  logic        memErr;
  logic [2:0]  state;
`ifdef MC_PERF_CNT_EN
  logic [31:0] instRet;

  modport master (
    output OpCode, zero, memRdy,
    input  irWrite, pcWrite, bra, branch, regWrite, regDes, aluSrc,
           memR, memW, MemToReg, notStri, illegal, memErr, state, instRet
  );
  modport slave (
    input  OpCode, zero, memRdy,
    output irWrite, pcWrite, bra, branch, regWrite, regDes, aluSrc,
           memR, memW, MemToReg, notStri, illegal, memErr, state, instRet
  );
`else
  modport master (
    output OpCode, zero, memRdy,
    input  irWrite, pcWrite, bra, branch, regWrite, regDes, aluSrc,
           memR, memW, MemToReg, notStri, illegal, memErr, state
  );
  modport slave (
    input  OpCode, zero, memRdy,
    output irWrite, pcWrite, bra, branch, regWrite, regDes, aluSrc,
           memR, memW, MemToReg, notStri, illegal, memErr, state
  );
`endif
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT sequencing for the
// 4-bit-opcode datapath with a memory-wait timeout.
// Outputs are decoded combinationally from state/opcode register/counter so
// that memory-ready strobes (IR/PC load) land in the same cycle as memRdy.
// Define MC_PERF_CNT_EN to add the retired-instruction counter (bus.instRet).
module multicycle_ctrl #(
  parameter int CNT_W       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_ctrl_if.slave     bus
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);
  localparam logic [3:0] OP_ADDI = 4'd8;
  localparam logic [3:0] OP_LW   = 4'd9;
  localparam logic [3:0] OP_SW   = 4'd10;
  localparam logic [3:0] OP_BEQ  = 4'd11;
  localparam logic [3:0] OP_BRA  = 4'd13;
  localparam logic [3:0] OP_HALT = 4'd15;

  state_t           cur_state;
  logic [3:0]       op_reg;
  logic [CNT_W-1:0] cnt;
  logic             timeout_hit;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op == 4'd12) || (op == 4'd14);
  endfunction

  function automatic logic is_rtype(input logic [3:0] op);
    return (op[3] == 1'b0);
  endfunction

  // A wait phase expires when the counter reaches the limit and memory is still busy.
  assign timeout_hit = (cnt == TMO) && !bus.memRdy;

  // State, latched opcode and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= ST_FETCH;
      op_reg    <= 4'd0;
      cnt       <= {CNT_W{1'b0}};
    end else begin
      case (cur_state)
        ST_FETCH: begin
          if (bus.memRdy) begin
            cur_state <= ST_DECODE;
            cnt       <= {CNT_W{1'b0}};
          end else if (timeout_hit) begin
            cur_state <= ST_FETCH;
            cnt       <= {CNT_W{1'b0}};
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DECODE: begin
          op_reg <= bus.OpCode;
          cnt    <= {CNT_W{1'b0}};
          if (is_illegal(bus.OpCode)) begin
            cur_state <= ST_FETCH;
          end else if (bus.OpCode == OP_HALT) begin
            cur_state <= ST_HALT;
          end else begin
            cur_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          cnt <= {CNT_W{1'b0}};
          if ((op_reg == OP_LW) || (op_reg == OP_SW)) begin
            cur_state <= ST_MEM;
          end else if (op_reg <= OP_ADDI) begin
            cur_state <= ST_WB;
          end else begin
            cur_state <= ST_FETCH;
          end
        end
        ST_MEM: begin
          if (bus.memRdy) begin
            cur_state <= (op_reg == OP_LW) ? ST_WB : ST_FETCH;
            cnt       <= {CNT_W{1'b0}};
          end else if (timeout_hit) begin
            cur_state <= ST_FETCH;
            cnt       <= {CNT_W{1'b0}};
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_WB: begin
          cur_state <= ST_FETCH;
          cnt       <= {CNT_W{1'b0}};
        end
        ST_HALT: begin
          cur_state <= ST_HALT;
        end
        default: begin
          cur_state <= ST_FETCH;
          cnt       <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Control strobe decode; everything is forced low while reset is held.
  always_comb begin
    bus.irWrite  = 1'b0;
    bus.pcWrite  = 1'b0;
    bus.bra      = 1'b0;
    bus.branch   = 1'b0;
    bus.regWrite = 1'b0;
    bus.regDes   = 1'b0;
    bus.aluSrc   = 1'b0;
    bus.memR     = 1'b0;
    bus.memW     = 1'b0;
    bus.MemToReg = 1'b0;
    bus.notStri  = 1'b0;
    bus.illegal  = 1'b0;
    bus.memErr   = 1'b0;
    bus.state    = cur_state;
    if (rst) begin
      bus.state = ST_FETCH;
    end else begin
      case (cur_state)
        ST_FETCH: begin
          bus.memR    = 1'b1;
          bus.notStri = 1'b1;
          if (bus.memRdy) begin
            bus.irWrite = 1'b1;
            bus.pcWrite = 1'b1;
          end else begin
            bus.memErr = timeout_hit;
          end
        end
        ST_DECODE: begin
          bus.notStri = 1'b1;
          bus.illegal = is_illegal(bus.OpCode);
        end
        ST_EXEC: begin
          bus.notStri = (op_reg != OP_SW);
          bus.aluSrc  = (op_reg == OP_ADDI) || (op_reg == OP_LW) || (op_reg == OP_SW);
          if (op_reg == OP_BEQ) begin
            bus.branch  = 1'b1;
            bus.pcWrite = bus.zero;
          end else if (op_reg == OP_BRA) begin
            bus.bra     = 1'b1;
            bus.pcWrite = 1'b1;
          end else begin
            bus.pcWrite = 1'b0;
          end
        end
        ST_MEM: begin
          bus.notStri = (op_reg != OP_SW);
          bus.memR    = (op_reg == OP_LW);
          bus.memW    = (op_reg == OP_SW);
          if (bus.memRdy) begin
            bus.memErr = 1'b0;
          end else begin
            bus.memErr = timeout_hit;
          end
        end
        ST_WB: begin
          bus.notStri  = (op_reg != OP_SW);
          bus.regWrite = 1'b1;
          bus.regDes   = is_rtype(op_reg);
          bus.MemToReg = (op_reg == OP_LW);
        end
        ST_HALT: begin
          bus.notStri = 1'b0;
        end
        default: begin
          bus.notStri = 1'b0;
        end
      endcase
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [31:0] inst_ret;
  logic        retire;

  // An instruction retires when it leaves WB, a completing SW MEM, or a branch EXEC.
  always_comb begin
    retire = 1'b0;
    case (cur_state)
      ST_WB:   retire = 1'b1;
      ST_MEM:  retire = (op_reg == OP_SW) && bus.memRdy;
      ST_EXEC: retire = (op_reg == OP_BEQ) || (op_reg == OP_BRA);
      default: retire = 1'b0;
    endcase
  end

  // Free-running retired-instruction count, wrapping at 2**32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_ret <= 32'd0;
    end else if (retire) begin
      inst_ret <= inst_ret + 32'd1;
    end else begin
      inst_ret <= inst_ret;
    end
  end

  assign bus.instRet = inst_ret;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. Each instruction is expanded from
// the behavioural rules into a per-cycle trace of inputs and expected outputs
// (memory wait lengths, timeout, abort, halt, reset), then replayed on the DUT.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] state;
    logic irWrite;
    logic pcWrite;
    logic bra;
    logic branch;
    logic regWrite;
    logic regDes;
    logic aluSrc;
    logic memR;
    logic memW;
    logic MemToReg;
    logic notStri;
    logic illegal;
    logic memErr;
  } out_t;

  typedef struct {
    logic        rst;
    logic [3:0]  op;
    logic        zero;
    logic        rdy;
    out_t        exp;
    logic [31:0] ret;
  } cyc_t;

  logic clk;
  logic rst;
  multicycle_ctrl_if bus();

  multicycle_ctrl #(.CNT_W(4), .MEM_TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cyc_t        trace[$];
  logic [31:0] model_ret;
  int          total;
  int          bad;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input out_t e, input logic [3:0] op, input logic rdy, input logic z);
    cyc_t c;
    c.rst  = 1'b0;
    c.op   = op;
    c.zero = z;
    c.rdy  = rdy;
    c.exp  = e;
    c.ret  = model_ret;
    trace.push_back(c);
  endtask

  task automatic gen_reset(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c.rst  = 1'b1;
      c.op   = 4'($urandom);
      c.zero = 1'($urandom);
      c.rdy  = 1'($urandom);
      c.exp  = '0;
      c.ret  = 32'd0;
      trace.push_back(c);
    end
    model_ret = 32'd0;
  endtask

  // Memory wait phase: ready arrives after w idle cycles; 15 idle cycles then a 16th without ready aborts.
  task automatic gen_wait(input logic [2:0] st, input int w, input logic [3:0] op,
                          input logic rd, input logic wr, output logic ok);
    out_t e;
    ok = 1'b0;
    for (int k = 0; k < 16; k++) begin
      e = '0;
      e.state   = st;
      e.memR    = rd;
      e.memW    = wr;
      e.notStri = (st == 3'd0) ? 1'b1 : (op != 4'd10);
      if (k == w) begin
        if (st == 3'd0) begin
          e.irWrite = 1'b1;
          e.pcWrite = 1'b1;
        end
        push(e, 4'($urandom), 1'b1, 1'($urandom));
        ok = 1'b1;
        break;
      end
      if (k == 15) begin
        e.memErr = 1'b1;
        push(e, 4'($urandom), 1'b0, 1'($urandom));
        break;
      end
      push(e, 4'($urandom), 1'b0, 1'($urandom));
    end
  endtask

  task automatic gen_instr(input logic [3:0] op, input int fw, input int mw, input logic z);
    out_t e;
    logic ok;
    gen_wait(3'd0, fw, op, 1'b1, 1'b0, ok);
    if (!ok) return;
    e = '0;
    e.state   = 3'd1;
    e.notStri = 1'b1;
    e.illegal = (op == 4'd12) || (op == 4'd14);
    push(e, op, 1'($urandom), 1'($urandom));
    if (e.illegal) return;
    if (op == 4'd15) begin
      e = '0;
      e.state = 3'd5;
      for (int i = 0; i < 20; i++) push(e, 4'($urandom), 1'($urandom), 1'($urandom));
      gen_reset(2);
      return;
    end
    e = '0;
    e.state   = 3'd2;
    e.notStri = (op != 4'd10);
    e.aluSrc  = (op == 4'd8) || (op == 4'd9) || (op == 4'd10);
    if (op == 4'd11) begin
      e.branch  = 1'b1;
      e.pcWrite = z;
    end
    if (op == 4'd13) begin
      e.bra     = 1'b1;
      e.pcWrite = 1'b1;
    end
    push(e, 4'($urandom), 1'($urandom), z);
    if ((op == 4'd11) || (op == 4'd13)) begin
      model_ret++;
      return;
    end
    if ((op == 4'd9) || (op == 4'd10)) begin
      gen_wait(3'd3, mw, op, op == 4'd9, op == 4'd10, ok);
      if (!ok) return;
      if (op == 4'd10) begin
        model_ret++;
        return;
      end
    end
    e = '0;
    e.state    = 3'd4;
    e.notStri  = 1'b1;
    e.regWrite = 1'b1;
    e.regDes   = (op < 4'd8);
    e.MemToReg = (op == 4'd9);
    push(e, 4'($urandom), 1'($urandom), 1'($urandom));
    model_ret++;
  endtask

  function automatic int pick_wait();
    if ($urandom_range(0, 15) == 0) return int'($urandom_range(14, 17));
    return int'($urandom_range(0, 3));
  endfunction

  initial begin
    out_t got;
    int   start;
    int   len;
    int   keep;
    total     = 0;
    bad       = 0;
    model_ret = 32'd0;
    rst        = 1'b1;
    bus.OpCode = 4'd0;
    bus.zero   = 1'b0;
    bus.memRdy = 1'b0;

    // Directed scenarios.
    gen_reset(3);
    gen_instr(4'd3, 0, 0, 1'b0);
    gen_instr(4'd9, 0, 3, 1'b0);
    gen_instr(4'd11, 0, 0, 1'b0);
    gen_instr(4'd11, 0, 0, 1'b1);
    gen_instr(4'd13, 0, 0, 1'b0);
    gen_instr(4'd10, 0, 16, 1'b0);
    gen_instr(4'd10, 0, 15, 1'b0);
    gen_instr(4'd12, 0, 0, 1'b0);
    gen_instr(4'd14, 1, 0, 1'b0);
    gen_instr(4'd0, 16, 0, 1'b0);
    gen_instr(4'd8, 15, 0, 1'b0);
    gen_instr(4'd15, 0, 0, 1'b0);

    // Random instruction stream with occasional mid-instruction reset.
    for (int n = 0; n < 300; n++) begin
      start = trace.size();
      gen_instr(4'($urandom), pick_wait(), pick_wait(), 1'($urandom));
      if ($urandom_range(0, 19) == 0) begin
        len  = trace.size() - start;
        keep = int'($urandom_range(1, len));
        while (trace.size() > start + keep) void'(trace.pop_back());
        gen_reset(int'($urandom_range(1, 2)));
      end
    end

    foreach (trace[i]) begin
      @(posedge clk);
      #1;
      rst        = trace[i].rst;
      bus.OpCode = trace[i].op;
      bus.zero   = trace[i].zero;
      bus.memRdy = trace[i].rdy;
      @(negedge clk);
      got = {bus.state, bus.irWrite, bus.pcWrite, bus.bra, bus.branch, bus.regWrite,
             bus.regDes, bus.aluSrc, bus.memR, bus.memW, bus.MemToReg, bus.notStri,
             bus.illegal, bus.memErr};
      check_eq($sformatf("ctrl[cyc %0d]", i), 32'(got), 32'(trace[i].exp));
`ifdef MC_PERF_CNT_EN
      check_eq($sformatf("instRet[cyc %0d]", i), bus.instRet, trace[i].ret);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
